// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse domain: position width, screen limits,
// default cursor position, config sequencer state encoding and write payload.
package mouse_pkg;

  localparam int unsigned POS_W        = 12;
  localparam int unsigned SCREEN_MAX_X = 1023;
  localparam int unsigned SCREEN_MAX_Y = 767;
  localparam int unsigned DEF_POS_X    = 50;
  localparam int unsigned DEF_POS_Y    = 679;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WMAXX = 3'd1,
    WMAXY = 3'd2,
    WX    = 3'd3,
    WY    = 3'd4,
    GAP   = 3'd5
  } cfg_state_e;

  // One-hot write strobes towards MouseCtl
  typedef struct packed {
    logic setmax_x;
    logic setmax_y;
    logic setx;
    logic sety;
  } mouse_wr_t;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                  input logic [POS_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/mouse_cfg_gap_cnt.sv
// Loadable down-counter with zero flag; times the idle gap between writes.
module mouse_cfg_gap_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mouse_cfg_seq.sv
// Config sequencer for MouseCtl: loads limits/start position after reset and
// re-centres on request. Optional macro MOUSE_CFG_CLAMP_EN clamps positions to the limits.
module mouse_cfg_seq
  import mouse_pkg::*;
#(
  parameter int unsigned MAX_X   = SCREEN_MAX_X,
  parameter int unsigned MAX_Y   = SCREEN_MAX_Y,
  parameter int unsigned INIT_X  = DEF_POS_X,
  parameter int unsigned INIT_Y  = DEF_POS_Y,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_req,
  input  logic             rc_req,
  input  logic [POS_W-1:0] rc_x,
  input  logic [POS_W-1:0] rc_y,
  output logic [POS_W-1:0] value,
  output logic             setx,
  output logic             sety,
  output logic             setmax_x,
  output logic             setmax_y,
  output logic             busy,
  output logic             cfg_done,
  output logic             rc_ack
);

  localparam logic [POS_W-1:0] MAX_X_V = POS_W'(MAX_X);
  localparam logic [POS_W-1:0] MAX_Y_V = POS_W'(MAX_Y);
`ifdef MOUSE_CFG_CLAMP_EN
  localparam logic [POS_W-1:0] INIT_X_V = clamp_pos(POS_W'(INIT_X), MAX_X_V);
  localparam logic [POS_W-1:0] INIT_Y_V = clamp_pos(POS_W'(INIT_Y), MAX_Y_V);
`else
  localparam logic [POS_W-1:0] INIT_X_V = POS_W'(INIT_X);
  localparam logic [POS_W-1:0] INIT_Y_V = POS_W'(INIT_Y);
`endif

  localparam int unsigned CNT_W = ($clog2(GAP_CYC) > 3) ? $clog2(GAP_CYC) : 3;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);

  cfg_state_e       state_q, state_d;
  cfg_state_e       ret_q, ret_d;
  mouse_wr_t        wr_q, wr_d;
  logic [POS_W-1:0] value_q, value_d;
  logic             busy_q, busy_d;
  logic             cfg_done_q, cfg_done_d;
  logic             rc_ack_q, rc_ack_d;
  logic             cfg_pend_q, cfg_pend_d;
  logic             rc_pend_q, rc_pend_d;
  logic [POS_W-1:0] rc_x_q, rc_x_d;
  logic [POS_W-1:0] rc_y_q, rc_y_d;
  logic [POS_W-1:0] act_y_q, act_y_d;
  logic             seq_cfg_q, seq_cfg_d;
  logic             take_cfg, take_rc;
  logic             gap_load, gap_dec, gap_zero_c;
  logic [POS_W-1:0] rc_x_in_c, rc_y_in_c;

`ifdef MOUSE_CFG_CLAMP_EN
  assign rc_x_in_c = clamp_pos(rc_x, MAX_X_V);
  assign rc_y_in_c = clamp_pos(rc_y, MAX_Y_V);
`else
  assign rc_x_in_c = rc_x;
  assign rc_y_in_c = rc_y;
`endif

  mouse_cfg_gap_cnt #(
    .W (CNT_W)
  ) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero_c   (gap_zero_c)
  );

  // State and output registers; a full config is pending out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      wr_q       <= '0;
      value_q    <= '0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      rc_ack_q   <= 1'b0;
      cfg_pend_q <= 1'b1;
      rc_pend_q  <= 1'b0;
      rc_x_q     <= '0;
      rc_y_q     <= '0;
      act_y_q    <= '0;
      seq_cfg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      wr_q       <= wr_d;
      value_q    <= value_d;
      busy_q     <= busy_d;
      cfg_done_q <= cfg_done_d;
      rc_ack_q   <= rc_ack_d;
      cfg_pend_q <= cfg_pend_d;
      rc_pend_q  <= rc_pend_d;
      rc_x_q     <= rc_x_d;
      rc_y_q     <= rc_y_d;
      act_y_q    <= act_y_d;
      seq_cfg_q  <= seq_cfg_d;
    end
  end

  // Next state; each write's strobe and data are produced on the edge entering it
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    wr_d       = '0;
    value_d    = value_q;
    cfg_done_d = cfg_done_q;
    rc_ack_d   = 1'b0;
    act_y_d    = act_y_q;
    seq_cfg_d  = seq_cfg_q;
    take_cfg   = 1'b0;
    take_rc    = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_pend_q) begin
          state_d      = WMAXX;
          seq_cfg_d    = 1'b1;
          take_cfg     = 1'b1;
          wr_d.setmax_x = 1'b1;
          value_d      = MAX_X_V;
        end else if (rc_pend_q) begin
          state_d   = WX;
          seq_cfg_d = 1'b0;
          take_rc   = 1'b1;
          wr_d.setx = 1'b1;
          value_d   = rc_x_q;
          act_y_d   = rc_y_q;
        end
      end
      WMAXX: begin
        state_d  = GAP;
        ret_d    = WMAXY;
        gap_load = 1'b1;
      end
      WMAXY: begin
        state_d  = GAP;
        ret_d    = WX;
        gap_load = 1'b1;
      end
      WX: begin
        state_d  = GAP;
        ret_d    = WY;
        gap_load = 1'b1;
      end
      WY: begin
        state_d = IDLE;
      end
      GAP: begin
        if (gap_zero_c) begin
          state_d = ret_q;
          case (ret_q)
            WMAXY: begin
              wr_d.setmax_y = 1'b1;
              value_d       = MAX_Y_V;
            end
            WX: begin
              wr_d.setx = 1'b1;
              value_d   = INIT_X_V;
            end
            WY: begin
              wr_d.sety = 1'b1;
              value_d   = seq_cfg_q ? INIT_Y_V : act_y_q;
              if (seq_cfg_q) cfg_done_d = 1'b1;
              else           rc_ack_d   = 1'b1;
            end
            default: ;
          endcase
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d != IDLE);
    cfg_pend_d = (cfg_pend_q & ~take_cfg) | cfg_req;
    rc_pend_d  = (rc_pend_q & ~take_rc) | rc_req;
    rc_x_d     = rc_req ? rc_x_in_c : rc_x_q;
    rc_y_d     = rc_req ? rc_y_in_c : rc_y_q;
  end

  assign value    = value_q;
  assign setx     = wr_q.setx;
  assign sety     = wr_q.sety;
  assign setmax_x = wr_q.setmax_x;
  assign setmax_y = wr_q.setmax_y;
  assign busy     = busy_q;
  assign cfg_done = cfg_done_q;
  assign rc_ack   = rc_ack_q;

endmodule

// File: tb/tb_mouse_cfg_seq.sv
// Bench for mouse_cfg_seq: directed scenarios plus random requests, checked
// against a write-schedule model of the sequencer.
module tb_mouse_cfg_seq;

  localparam int G = 4;

  logic        clk;
  logic        rst;
  logic        cfg_req;
  logic        rc_req;
  logic [11:0] rc_x;
  logic [11:0] rc_y;
  logic [11:0] value;
  logic        setx;
  logic        sety;
  logic        setmax_x;
  logic        setmax_y;
  logic        busy;
  logic        cfg_done;
  logic        rc_ack;

  mouse_cfg_seq #(
    .GAP_CYC (G)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_req  (cfg_req),
    .rc_req   (rc_req),
    .rc_x     (rc_x),
    .rc_y     (rc_y),
    .value    (value),
    .setx     (setx),
    .sety     (sety),
    .setmax_x (setmax_x),
    .setmax_y (setmax_y),
    .busy     (busy),
    .cfg_done (cfg_done),
    .rc_ack   (rc_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scheduled write: edge number, strobe mask {setmax_x,setmax_y,setx,sety}, data
  typedef struct {
    int       cyc;
    logic [3:0] mask;
    int       val;
    bit       is_cfg;
  } ev_t;

  ev_t        ev_q[$];
  int         m_edge;
  bit         m_cfg_pend;
  bit         m_rc_pend;
  int         m_rcx;
  int         m_rcy;
  int         m_idle_from;
  int         m_busy_lo;
  int         m_busy_hi;
  int         m_value;
  bit         m_cfg_done;
  logic [3:0] m_strobe;
  bit         m_ack;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, m_edge, got, exp);
    end
  endtask

  function automatic void model_reset();
    ev_q.delete();
    m_edge      = 0;
    m_cfg_pend  = 1'b1;
    m_rc_pend   = 1'b0;
    m_rcx       = 0;
    m_rcy       = 0;
    m_idle_from = 0;
    m_busy_lo   = -1;
    m_busy_hi   = -1;
    m_value     = 0;
    m_cfg_done  = 1'b0;
    m_strobe    = 4'b0000;
    m_ack       = 1'b0;
  endfunction

  function automatic ev_t mk_ev(int cyc, logic [3:0] mask, int val, bit is_cfg);
    ev_t e;
    e.cyc = cyc; e.mask = mask; e.val = val; e.is_cfg = is_cfg;
    return e;
  endfunction

  // Advance the model by one clock edge with the inputs sampled on that edge
  function automatic void model_edge(bit c, bit r, int x, int y);
    int  last;
    ev_t e;
    m_edge++;
    m_strobe = 4'b0000;
    m_ack    = 1'b0;
    if ((m_edge - 1 >= m_idle_from) && (m_cfg_pend || m_rc_pend)) begin
      if (m_cfg_pend) begin
        ev_q.push_back(mk_ev(m_edge,             4'b1000, 1023, 1'b1));
        ev_q.push_back(mk_ev(m_edge + (G+1),     4'b0100, 767,  1'b1));
        ev_q.push_back(mk_ev(m_edge + 2*(G+1),   4'b0010, 50,   1'b1));
        ev_q.push_back(mk_ev(m_edge + 3*(G+1),   4'b0001, 679,  1'b1));
        m_cfg_pend = 1'b0;
        last = m_edge + 3*(G+1);
      end else begin
        ev_q.push_back(mk_ev(m_edge,         4'b0010, m_rcx, 1'b0));
        ev_q.push_back(mk_ev(m_edge + (G+1), 4'b0001, m_rcy, 1'b0));
        m_rc_pend = 1'b0;
        last = m_edge + (G+1);
      end
      m_busy_lo   = m_edge;
      m_busy_hi   = last;
      m_idle_from = last + 1;
    end
    if (ev_q.size() > 0 && ev_q[0].cyc == m_edge) begin
      e = ev_q.pop_front();
      m_strobe = e.mask;
      m_value  = e.val;
      if (e.mask == 4'b0001) begin
        if (e.is_cfg) m_cfg_done = 1'b1;
        else          m_ack      = 1'b1;
      end
    end
    if (c) m_cfg_pend = 1'b1;
    if (r) begin
      m_rc_pend = 1'b1;
`ifdef MOUSE_CFG_CLAMP_EN
      m_rcx = (x > 1023) ? 1023 : x;
      m_rcy = (y > 767) ? 767 : y;
`else
      m_rcx = x;
      m_rcy = y;
`endif
    end
  endfunction

  task automatic check_outputs();
    check_eq("strobes", 32'({setmax_x, setmax_y, setx, sety}), 32'(m_strobe));
    check_eq("value", 32'(value), 32'(m_value));
    check_eq("busy", 32'(busy), 32'((m_edge >= m_busy_lo) && (m_edge <= m_busy_hi)));
    check_eq("cfg_done", 32'(cfg_done), 32'(m_cfg_done));
    check_eq("rc_ack", 32'(rc_ack), 32'(m_ack));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_value"}, 32'(value), 32'd0);
    check_eq({tag, "_strobes"}, 32'({setmax_x, setmax_y, setx, sety}), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_cfg_done"}, 32'(cfg_done), 32'd0);
    check_eq({tag, "_rc_ack"}, 32'(rc_ack), 32'd0);
  endtask

  // Called at a falling edge: drive, take the rising edge, then check
  task automatic step(input bit c, input bit r, input int x, input int y);
    cfg_req = c;
    rc_req  = r;
    rc_x    = 12'(x);
    rc_y    = 12'(y);
    @(posedge clk);
    model_edge(c, r, x, y);
    @(negedge clk);
    check_outputs();
    cfg_req = 1'b0;
    rc_req  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    rst     = 1'b0;
    cfg_req = 1'b0;
    rc_req  = 1'b0;
    rc_x    = '0;
    rc_y    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // Auto config after release
    rst = 1'b1;
    idle(20);

    // Plain re-centre from idle
    step(1'b0, 1'b1, 300, 200);
    idle(10);

    // Simultaneous requests: config first, then re-centre
    step(1'b1, 1'b1, 10, 20);
    idle(30);

    // Two re-centre requests during a config merge, latest coordinates win
    step(1'b1, 1'b0, 0, 0);
    idle(2);
    step(1'b0, 1'b1, 100, 100);
    idle(4);
    step(1'b0, 1'b1, 400, 500);
    idle(30);

    // Out-of-range coordinates
    step(1'b0, 1'b1, 2000, 900);
    idle(10);

    // Re-centre queued behind a running re-centre
    step(1'b0, 1'b1, 5, 6);
    idle(2);
    step(1'b0, 1'b1, 7, 8);
    idle(16);

    // Request arriving with the last write of a sequence
    step(1'b0, 1'b1, 11, 12);
    idle(G + 1);
    step(1'b0, 1'b1, 13, 14);
    idle(12);

    // Asynchronous reset during WMAXY with a re-centre queued
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 77, 88);
    idle(5);
    check_eq("pre_reset_setmax_y", 32'(setmax_y), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    check_reset_outputs("held_reset");
    rst = 1'b1;
    idle(25);

    // Random request traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
           int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
